// File: rtl/serializer_4.sv
// serializer_4: captures four N-bit words in one load cycle and streams them
// out one per valid/ready beat, steering a mux_4 with the word counter.
module mux_4 #(
   parameter int N = 64
) (
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   input  logic [N-1:0] d2,
   input  logic [N-1:0] d3,
   input  logic [1:0]   s,
   output logic [N-1:0] y
);
   always_comb y = s[1] ? (s[0] ? d3 : d2) : (s[0] ? d1 : d0);
endmodule

module serializer_4 #(
   parameter int N = 64
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [1:0]   i_len,
   input  logic [N-1:0] i_in0,
   input  logic [N-1:0] i_in1,
   input  logic [N-1:0] i_in2,
   input  logic [N-1:0] i_in3,
   input  logic         i_ready,
   output logic         o_busy,
   output logic         o_valid,
   output logic         o_last,
   output logic [1:0]   o_s,
   output logic [N-1:0] o_out
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t       state;
   logic [1:0]   cnt;
   logic [1:0]   len;
   logic [N-1:0] w0, w1, w2, w3;
   logic [N-1:0] mux_y;
   logic         send;
   logic         at_last;

   assign send    = state == SEND;
   assign at_last = cnt == len;

   mux_4 #(.N(N)) u_mux (
      .d0(w0),
      .d1(w1),
      .d2(w2),
      .d3(w3),
      .s (cnt),
      .y (mux_y)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= 2'd0;
         len   <= 2'd0;
         w0    <= '0;
         w1    <= '0;
         w2    <= '0;
         w3    <= '0;
      end else if (state == IDLE) begin
         if (i_load) begin
            state <= SEND;
            cnt   <= 2'd0;
            len   <= i_len;
            w0    <= i_in0;
            w1    <= i_in1;
            w2    <= i_in2;
            w3    <= i_in3;
         end
      end else if (i_ready) begin
         // the length check ends the burst before the counter can wrap
         if (at_last) begin
            state <= IDLE;
            cnt   <= 2'd0;
         end else begin
            cnt <= cnt + 2'd1;
         end
      end
   end

   assign o_busy  = send;
   assign o_valid = send;
   assign o_last  = send && at_last;
   assign o_s     = send ? cnt : 2'd0;
   assign o_out   = send ? mux_y : '0;
endmodule

// File: tb/tb_serializer_4.sv
// tb_serializer_4: directed self-checking bench for serializer_4.
module tb_serializer_4;
   localparam int N = 64;
   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [1:0]   len;
   logic [N-1:0] in0, in1, in2, in3;
   logic         ready;
   logic         busy, valid, last;
   logic [1:0]   s;
   logic [N-1:0] out;
   int           n_cmp = 0;
   int           n_bad = 0;

   serializer_4 #(.N(N)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_load (load),
      .i_len  (len),
      .i_in0  (in0),
      .i_in1  (in1),
      .i_in2  (in2),
      .i_in3  (in3),
      .i_ready(ready),
      .o_busy (busy),
      .o_valid(valid),
      .o_last (last),
      .o_s    (s),
      .o_out  (out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input string tag, input logic [N-1:0] e_out, input logic [1:0] e_s, input logic e_last);
      chk({tag, ".valid"}, N'(valid), N'(1));
      chk({tag, ".busy"}, N'(busy), N'(1));
      chk({tag, ".out"}, out, e_out);
      chk({tag, ".s"}, N'(s), N'(e_s));
      chk({tag, ".last"}, N'(last), N'(e_last));
   endtask

   task automatic idle(input string tag);
      chk({tag, ".valid"}, N'(valid), N'(0));
      chk({tag, ".busy"}, N'(busy), N'(0));
      chk({tag, ".last"}, N'(last), N'(0));
      chk({tag, ".s"}, N'(s), N'(0));
      chk({tag, ".out"}, out, '0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [1:0] l, input logic [N-1:0] a, b, c, d);
      load = 1'b1;
      len  = l;
      in0  = a;
      in1  = b;
      in2  = c;
      in3  = d;
      step();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; len = 2'd0; ready = 1'b0;
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      #2;
      idle("reset");
      step();
      rst = 1'b0;
      step();
      idle("post_reset");

      // 1: full burst, ready held high
      ready = 1'b1;
      ld(2'd3, 1, 2, 3, 4);
      beat("t1b0", 1, 0, 0); step();
      beat("t1b1", 2, 1, 0); step();
      beat("t1b2", 3, 2, 0); step();
      beat("t1b3", 4, 3, 1); step();
      idle("t1end");

      // 2: three stall cycles before each beat
      ready = 1'b0;
      ld(2'd3, 1, 2, 3, 4);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 3; k++) begin
            beat("t2stall", N'(i + 1), 2'(i), i == 3);
            step();
         end
         beat("t2beat", N'(i + 1), 2'(i), i == 3);
         ready = 1'b1;
         step();
         ready = 1'b0;
      end
      idle("t2end");

      // 3: short burst of two words
      ready = 1'b1;
      ld(2'd1, 10, 20, 30, 40);
      beat("t3b0", 10, 0, 0); step();
      beat("t3b1", 20, 1, 1); step();
      idle("t3end");

      // 4: load pulse during SEND is ignored
      ld(2'd3, 1, 2, 3, 4);
      beat("t4b0", 1, 0, 0);
      load = 1'b1; in0 = 9; in1 = 9; in2 = 9; in3 = 9; len = 2'd0;
      step();
      load = 1'b0;
      beat("t4b1", 2, 1, 0); step();
      beat("t4b2", 3, 2, 0); step();
      beat("t4b3", 4, 3, 1); step();
      idle("t4end");

      // 5: asynchronous reset mid-burst
      ld(2'd3, 1, 2, 3, 4);
      step(); step();
      beat("t5pre", 3, 2, 0);
      #2 rst = 1'b1;
      #1 idle("t5async");
      rst = 1'b0;
      step();
      idle("t5after");
      ld(2'd3, 5, 6, 7, 8);
      beat("t5b0", 5, 0, 0); step();
      beat("t5b1", 6, 1, 0); step();
      beat("t5b2", 7, 2, 0); step();
      beat("t5b3", 8, 3, 1); step();
      idle("t5end");

      // reset and load together: reset wins
      rst = 1'b1; load = 1'b1; len = 2'd3; in0 = 55;
      step();
      idle("rst_load");
      rst = 1'b0; load = 1'b0;
      step();
      idle("rst_load2");

      // 6: load held high with single-word bursts
      load = 1'b1; len = 2'd0; in0 = 7; in1 = 1; in2 = 2; in3 = 3;
      for (int i = 0; i < 3; i++) begin
         step();
         beat("t6v", 7, 0, 1);
         step();
         idle("t6gap");
      end
      load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
